cl2_csr_irq_ctrl: RTL
=====================

CL2_CSR_IRQ_CTRL -- requirements
Module: cl2_csr_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_LOCAL_IRQ, default 16, range 0..16: platform interrupt count, mapped to mip/mie bits 16+i.
REQ-002 SHALL have parameter MTVEC_RST, default 32'h0000_0000: mtvec reset value.
REQ-003 clk_i  in  1  sole clock; all state on rising edge.
REQ-004 rst_n_i  in  1  asynchronous, active-low reset.
REQ-005 csr_addr_i  in  12  CSR address.
REQ-006 csr_we_i  in  1  write strobe, full-word write.
REQ-007 csr_wdata_i  in  32  write data.
REQ-008 csr_rdata_o  out  32  combinational read data for csr_addr_i.
REQ-009 csr_hit_o  out  1  csr_addr_i decodes to an implemented CSR.
REQ-010 meip_i, mtip_i, msip_i  in  1 each  level-sensitive machine external/timer/software interrupts.
REQ-011 lcofip_i  in  1  counter-overflow interrupt, level.
REQ-012 local_irq_i  in  NUM_LOCAL_IRQ  platform interrupts, level; absent when NUM_LOCAL_IRQ=0.
REQ-013 irq_req_o  out  1  trap request to pipeline.
REQ-014 irq_cause_o  out  5  exception code of the requested interrupt.
REQ-015 irq_ack_i  in  1  pipeline takes the trap this cycle.
REQ-016 pc_i  in  32  PC saved to mepc on irq_ack_i.
REQ-017 trap_pc_o  out  32  target PC for the current irq_cause_o.
REQ-018 mret_i  in  1  pulse: mret retired.
REQ-019 mepc_o  out  32  current mepc.

Function
REQ-020 Implemented CSRs: mstatus 0x300 (only MIE bit3, MPIE bit7 writable; MPP bits 12:11 read 2'b11; others 0), mie 0x304, mtvec 0x305, mepc 0x341 (bits 1:0 read 0), mcause 0x342, mip 0x344 (read-only); other addresses: csr_hit_o=0, rdata 0, writes ignored.
REQ-021 mie writable bits: 3, 7, 11, 13, 16..15+NUM_LOCAL_IRQ; all others read 0.
REQ-022 mip bits 11/7/3/13/16+i SHALL be registered copies of meip_i/mtip_i/msip_i/lcofip_i/local_irq_i[i]; one-cycle latency input->mip.
REQ-023 pending = mip & mie; irq_req_o SHALL assert the cycle after pending!=0 and mstatus.MIE=1, irq_req_o=0.
REQ-024 Priority, highest first: 11, 3, 7, 13, then 16..15+NUM_LOCAL_IRQ, lower index higher.
REQ-025 irq_cause_o captured when irq_req_o rises; irq_req_o and irq_cause_o SHALL hold stable until irq_ack_i, even if the source deasserts.
REQ-026 On irq_ack_i while irq_req_o=1, next cycle: mepc=pc_i with bits 1:0 cleared, mcause={1'b1,26'b0,irq_cause_o}, MPIE=MIE, MIE=0, irq_req_o=0.
REQ-027 irq_ack_i while irq_req_o=0 SHALL be ignored.
REQ-028 On mret_i: MIE=MPIE, MPIE=1.
REQ-029 Same-cycle precedence: irq_ack_i > mret_i > CSR write for mstatus; irq_ack_i > CSR write for mepc/mcause.
REQ-030 CSR write clearing mstatus.MIE or the matching mie bit while irq_req_o=1 SHALL NOT withdraw the pending request.
REQ-031 irq_req_o SHALL not re-assert in the cycle it deasserts after ack.

Reset
REQ-032 On rst_n_i=0: mstatus MIE=0, MPIE=0; mie=0; mip=0; mepc=0; mcause=0; mtvec=MTVEC_RST; irq_req_o=0; irq_cause_o=0.
REQ-033 Reset mid-request SHALL drop irq_req_o immediately (asynchronously).

Configuration
REQ-034 Macro CL2_CSR_VECTORED_EN defined: mtvec[1:0] writable with values 0/1 only (2,3 write as 0); mode 1 gives trap_pc_o={mtvec[31:2],2'b0}+4*irq_cause_o.
REQ-035 CL2_CSR_VECTORED_EN undefined: mtvec[1:0] read 0; trap_pc_o={mtvec[31:2],2'b0}.

Verification
REQ-036 mie=0x800, MIE=1, meip_i=1 at cycle 0 -> irq_req_o=1 at cycle 2, irq_cause_o=11.
REQ-037 msip_i, mtip_i, meip_i all 1, mie=0x888, MIE=1 -> cause 11; after ack and meip_i=0, mret -> cause 3.
REQ-038 Request pending, pc_i=0x8000_0102, irq_ack_i=1 -> mepc=0x8000_0100, mcause=0x8000_000B, MIE=0, MPIE=1; mret_i -> MIE=1.
REQ-039 NUM_LOCAL_IRQ=4, local_irq_i=4'b1010, mie=0x000A_0000, MIE=1 -> irq_cause_o=17.
REQ-040 CL2_CSR_VECTORED_EN, mtvec write 0x0000_1001, cause 7 -> trap_pc_o=0x0000_101C; undefined -> 0x0000_1000.
REQ-041 Same-cycle irq_ack_i, mret_i and mstatus write 0x8 with MIE=1 -> MIE=0, MPIE=1 next cycle.

Source files
------------

// File: rtl/cl2_csr_irq_ctrl.sv
// cl2_csr_irq_ctrl: machine-mode CSR block and interrupt requester.
// Holds mstatus/mie/mtvec/mepc/mcause/mip and raises one trap request to
// the pipeline. The request holds its cause until the pipeline acknowledges it.
// Optional macro CL2_CSR_VECTORED_EN enables vectored mtvec mode (mtvec[1:0]=1).
//
// state   | meaning
// ST_IDLE | no request outstanding; watching pending & mstatus.MIE
// ST_REQ  | irq_req_o high, irq_cause_o frozen until irq_ack_i
module cl2_csr_irq_ctrl #(
  parameter int          NUM_LOCAL_IRQ = 16,
  parameter logic [31:0] MTVEC_RST     = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [11:0] csr_addr_i,
  input  logic        csr_we_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_hit_o,
  input  logic        meip_i,
  input  logic        mtip_i,
  input  logic        msip_i,
  input  logic        lcofip_i,
  input  logic [((NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1)-1:0] local_irq_i,
  output logic        irq_req_o,
  output logic [4:0]  irq_cause_o,
  input  logic        irq_ack_i,
  input  logic [31:0] pc_i,
  output logic [31:0] trap_pc_o,
  input  logic        mret_i,
  output logic [31:0] mepc_o
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  function automatic logic [31:0] irq_mask();
    logic [31:0] m;
    m = 32'h0000_2888;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) m[16+i] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] IRQ_MASK = irq_mask();

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t      state_q, state_d;
  logic        mstatus_mie_q, mstatus_mpie_q;
  logic [31:0] mie_q, mip_q, mip_d, mtvec_q, mepc_q, mcause_q;
  logic [4:0]  cause_q, enc_cause;
  logic [31:0] pending;
  logic        take_trap;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^pc_i[1:0];
  assign pending       = mip_q & mie_q;
  assign take_trap     = (state_q == ST_REQ) && irq_ack_i;

  // Gather the level-sensitive sources into mip bit positions
  always_comb begin
    mip_d     = '0;
    mip_d[11] = meip_i;
    mip_d[7]  = mtip_i;
    mip_d[3]  = msip_i;
    mip_d[13] = lcofip_i;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) mip_d[16+i] = local_irq_i[i];
  end

  // Priority encoder: later assignments win, so lowest priority goes first
  always_comb begin
    enc_cause = 5'd0;
    for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--)
      if (pending[16+i]) enc_cause = 5'(16 + i);
    if (pending[13]) enc_cause = 5'd13;
    if (pending[7])  enc_cause = 5'd7;
    if (pending[3])  enc_cause = 5'd3;
    if (pending[11]) enc_cause = 5'd11;
  end

  // Request FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Request FSM next state; once raised, only an ack withdraws the request
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if ((|pending) && mstatus_mie_q) state_d = ST_REQ;
      ST_REQ:  if (irq_ack_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Freeze the cause as the request rises
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      cause_q <= 5'd0;
    else if (state_q == ST_IDLE && state_d == ST_REQ)
      cause_q <= enc_cause;
  end

  // mip sampling and mie writes
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mip_q <= '0;
      mie_q <= '0;
    end else begin
      mip_q <= mip_d & IRQ_MASK;
      if (csr_we_i && csr_addr_i == A_MIE) mie_q <= csr_wdata_i & IRQ_MASK;
    end
  end

  // mstatus: trap entry beats mret beats a CSR write
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
    end else if (take_trap) begin
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (mret_i) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (csr_we_i && csr_addr_i == A_MSTATUS) begin
      mstatus_mie_q  <= csr_wdata_i[3];
      mstatus_mpie_q <= csr_wdata_i[7];
    end
  end

  // mepc/mcause: trap entry beats a CSR write
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (take_trap) begin
      mepc_q   <= {pc_i[31:2], 2'b00};
      mcause_q <= {1'b1, 26'd0, cause_q};
    end else if (csr_we_i) begin
      if (csr_addr_i == A_MEPC)   mepc_q   <= {csr_wdata_i[31:2], 2'b00};
      if (csr_addr_i == A_MCAUSE) mcause_q <= csr_wdata_i;
    end
  end

`ifdef CL2_CSR_VECTORED_EN
  // mtvec with mode field; reserved modes 2/3 collapse to direct
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      mtvec_q <= {MTVEC_RST[31:2], 1'b0, (MTVEC_RST[1:0] == 2'b01)};
    else if (csr_we_i && csr_addr_i == A_MTVEC)
      mtvec_q <= {csr_wdata_i[31:2], 1'b0, (csr_wdata_i[1:0] == 2'b01)};
  end

  assign trap_pc_o = mtvec_q[0] ? ({mtvec_q[31:2], 2'b00} + {25'd0, cause_q, 2'b00})
                                : {mtvec_q[31:2], 2'b00};
`else
  // mtvec, direct mode only
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      mtvec_q <= {MTVEC_RST[31:2], 2'b00};
    else if (csr_we_i && csr_addr_i == A_MTVEC)
      mtvec_q <= {csr_wdata_i[31:2], 2'b00};
  end

  assign trap_pc_o = {mtvec_q[31:2], 2'b00};
`endif

  // Combinational CSR read decode
  always_comb begin
    csr_rdata_o = '0;
    csr_hit_o   = 1'b1;
    case (csr_addr_i)
      A_MSTATUS: csr_rdata_o = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      A_MIE:     csr_rdata_o = mie_q;
      A_MTVEC:   csr_rdata_o = mtvec_q;
      A_MEPC:    csr_rdata_o = mepc_q;
      A_MCAUSE:  csr_rdata_o = mcause_q;
      A_MIP:     csr_rdata_o = mip_q;
      default:   csr_hit_o   = 1'b0;
    endcase
  end

  assign irq_req_o   = (state_q == ST_REQ);
  assign irq_cause_o = cause_q;
  assign mepc_o      = mepc_q;

endmodule
